// File: rtl/mips_pkg.sv
// Shared opcodes, FSM states and access widths for the MEM stage.
// Imported by mem_stage and mem_lane_align.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } width_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus.
// master: MEM stage drives request side; slave: the memory.
interface mem_stage_if;

  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBe;
  logic [31:0] MemWdata;
  logic        MemAck;
  logic [31:0] MemRdata;

  modport master (
    output MemReq, MemWe, MemAddr, MemBe, MemWdata,
    input  MemAck, MemRdata
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemBe, MemWdata,
    output MemAck, MemRdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Lane steering: store width/offset/data -> be/wdata,
// load width/sign/offset/raw word -> extended ld_data.
module mem_lane_align
  import mips_pkg::*;
(
  input  width_e      width,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    be    = 4'hF;
    wdata = st_data;
    case (width)
      BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{st_data[7:0]}};
      end
      HALF: begin
        be    = 4'b0011 << off;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_b = ld_raw[7:0];
    case (off)
      2'd1:    ld_b = ld_raw[15:8];
      2'd2:    ld_b = ld_raw[23:16];
      2'd3:    ld_b = ld_raw[31:24];
      default: ld_b = ld_raw[7:0];
    endcase
    ld_h = off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (width)
      BYTE:    ld_data = {{24{sgn & ld_b[7]}}, ld_b};
      HALF:    ld_data = {{16{sgn & ld_h[15]}}, ld_h};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one bus access per load/store, stall upstream,
// timeout -> BusErr; misaligned ops flagged without a bus cycle.
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InValid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  mem_stage_if.master bus,
  output logic [31:0] LoadData,
  output logic        WbValid,
  output logic        Misalign,
  output logic        BusErr
);

  logic [5:0] op;
  logic       mem_op, is_ld, sgn, mis;
  width_e     wid;
  logic [1:0] off;
  logic       req_ok, start;
  logic       unused;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  width_e      wid_q, wid_d;
  logic        sgn_q, sgn_d, ld_q, ld_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ldata_q, ldata_d;
  logic        wb_q, wb_d, berr_q, berr_d;

  width_e      al_wid;
  logic        al_sgn;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld;

  assign op     = Ins[31:26];
  assign off    = Result[1:0];
  assign unused = ^Ins[25:0];

  always_comb begin
    mem_op = 1'b1;
    is_ld  = 1'b1;
    sgn    = 1'b0;
    wid    = WORD;
    unique case (1'b1)
      op == OP_LB:  begin wid = BYTE; sgn = 1'b1; end
      op == OP_LH:  begin wid = HALF; sgn = 1'b1; end
      op == OP_LW:  wid = WORD;
      op == OP_LBU: wid = BYTE;
      op == OP_LHU: wid = HALF;
      op == OP_SB:  begin wid = BYTE; is_ld = 1'b0; end
      op == OP_SH:  begin wid = HALF; is_ld = 1'b0; end
      op == OP_SW:  is_ld = 1'b0;
      default:      mem_op = 1'b0;
    endcase
  end

  assign mis = (wid == HALF && off[0]) ||
               (wid == WORD && off != 2'b00);

  // Combinational flags are gated by RST so every output is 0 in reset.
  assign req_ok   = RST && state_q == IDLE && InValid && mem_op;
  assign start    = req_ok && !mis;
  assign Misalign = req_ok && mis;
  assign Stall    = start || (RST && state_q == ACCESS);

  // Store steering uses the live instruction in IDLE; load extraction
  // uses the attributes captured at start while in ACCESS.
  assign al_wid = (state_q == IDLE) ? wid : wid_q;
  assign al_sgn = (state_q == IDLE) ? sgn : sgn_q;
  assign al_off = (state_q == IDLE) ? off : off_q;

  mem_lane_align u_align (
    .width   (al_wid),
    .sgn     (al_sgn),
    .off     (al_off),
    .st_data (Rdata2),
    .ld_raw  (bus.MemRdata),
    .be      (al_be),
    .wdata   (al_wdata),
    .ld_data (al_ld)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wid_d   = wid_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    ld_d    = ld_q;
    ldata_d = ldata_q;
    wb_d    = wb_q;
    berr_d  = berr_q;
    case (state_q)
      IDLE: begin
        ldata_d = '0;
        wb_d    = 1'b0;
        berr_d  = 1'b0;
        if (start) begin
          state_d = ACCESS;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = !is_ld;
          addr_d  = {Result[31:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          wid_d   = wid;
          sgn_d   = sgn;
          off_d   = off;
          ld_d    = is_ld;
        end
      end
      ACCESS: begin
        if (bus.MemAck) begin
          state_d = DONE;
          ldata_d = ld_q ? al_ld : '0;
          wb_d    = ld_q;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = DONE;
          berr_d  = 1'b1;
          ldata_d = '0;
          wb_d    = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
        if (state_d == DONE) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        ldata_d = '0;
        wb_d    = 1'b0;
        berr_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wid_q   <= WORD;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      ld_q    <= 1'b0;
      ldata_q <= '0;
      wb_q    <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wid_q   <= wid_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
      ldata_q <= ldata_d;
      wb_q    <= wb_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.MemReq   = req_q;
  assign bus.MemWe    = we_q;
  assign bus.MemAddr  = addr_q;
  assign bus.MemBe    = be_q;
  assign bus.MemWdata = wdata_q;
  assign LoadData     = ldata_q;
  assign WbValid      = wb_q;
  assign BusErr       = berr_q;

endmodule
